// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit: iterative RV32M multiply/divide unit.
// One operation in flight at a time. Multiply is shift-add and divide is
// restoring; both take one step per cycle over DATA_WIDTH cycles. Signs are
// stripped at accept time and restored in a single fix-up cycle. That same
// cycle also selects the RISC-V corner-case results.
//
// Handshake: a request is accepted on a rising edge where in_valid && in_ready.
// A result is consumed on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE and out_valid only in DONE, so the two never overlap.
// A request is not re-accepted in the cycle of the result handshake.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic [1:0]               dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;       // iteration index within CALC
  logic [2*W-1:0] acc;       // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [W-1:0]   opnd;      // mul: multiplicand magnitude; div: divisor magnitude
  logic [W-1:0]   a_orig;    // raw SrcA, returned by remainder-by-zero
  logic [2:0]     op;
  logic           neg_main;  // negate product / quotient
  logic           neg_rem;   // negate remainder (dividend was negative)
  logic           div_zero;
  logic           div_ovf;

  assign dbg_state = state;

  // Accept-time decode: operand signedness, magnitudes and sign flags
  logic [2:0]   new_op;
  logic         new_div;
  logic         a_signed;
  logic         b_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;

  always_comb begin
    new_op   = Operation[2:0];
    new_div  = new_op[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (new_op)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end // MULH
      3'b010:         begin a_signed = 1'b1; b_signed = 1'b0; end // MULHSU
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end // DIV, REM
      default:        begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
    a_neg = a_signed & SrcA[W-1];
    b_neg = b_signed & SrcB[W-1];
    mag_a = a_neg ? ({W{1'b0}} - SrcA) : SrcA;
    mag_b = b_neg ? ({W{1'b0}} - SrcB) : SrcB;
  end

  // One iteration step of each algorithm
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole register right by one.
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    // Restoring: bring the next dividend bit into the remainder, trial
    // subtract, and keep the difference only when it did not borrow.
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                            : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
  end

  // Fix-up: restore signs and select corner-case results
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_main ? ({(2*W){1'b0}} - acc) : acc;
    quo_fix  = neg_main ? ({W{1'b0}} - acc[W-1:0]) : acc[W-1:0];
    rem_fix  = neg_rem  ? ({W{1'b0}} - acc[2*W-1:W]) : acc[2*W-1:W];
    case (op)
      3'b000:                 fix_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
      3'b100, 3'b101: begin
        if (div_zero)     fix_res = {W{1'b1}};
        else if (div_ovf) fix_res = MOST_NEG;
        else              fix_res = quo_fix;
      end
      default: begin
        if (div_zero)     fix_res = a_orig;
        else if (div_ovf) fix_res = {W{1'b0}};
        else              fix_res = rem_fix;
      end
    endcase
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      a_orig    <= '0;
      op        <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      div_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            in_ready <= 1'b0;
            cnt      <= '0;
            op       <= new_op;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= new_div && (SrcB == {W{1'b0}});
            div_ovf  <= new_div && !new_op[0] && (SrcA == MOST_NEG) && (SrcB == {W{1'b1}});
            a_orig   <= SrcA;
            opnd     <= new_div ? mag_b : mag_a;
            acc      <= new_div ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          Result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// tb_muldiv_unit: randomized and directed bench for muldiv_unit against an
// arithmetic reference model and a cycle-level handshake model.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [2:0]   Operation = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] Result;
  logic [1:0]   dbg_state;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  bit           busy = 1'b0;
  logic [W-1:0] exp_last = '0;
  logic [W-1:0] exp_q[$];

  muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    int unsigned     uia, uib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;  ib = b;
    uia = a; uib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return uia / uib;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return uia % uib;
      end
    endcase
  endfunction

  // Scoreboard / compare process: every cycle, checks handshake outputs and
  // Result against the transaction model.
  always @(negedge clk) begin : compare
    logic exp_ov;
    cyc++;
    if (!rst_n) begin
      check("rst_in_ready", W'(in_ready), W'(1'b1));
      check("rst_out_valid", W'(out_valid), W'(1'b0));
      check("rst_result", Result, '0);
      busy = 1'b0;
      exp_q.delete();
      exp_last = '0;
    end else begin
      exp_ov = busy && ((cyc - acc_cyc) >= LAT);
      check("in_ready", W'(in_ready), W'(!busy));
      check("out_valid", W'(out_valid), W'(exp_ov));
      if (exp_ov && exp_q.size() > 0) check("result", Result, exp_q[0]);
      else if (!exp_ov) check("result_held", Result, exp_last);
      if (!busy && in_valid) begin
        exp_q.push_back(model(Operation, SrcA, SrcB));
        busy = 1'b1;
        acc_cyc = cyc;
      end else if (exp_ov && out_ready) begin
        exp_last = exp_q.pop_front();
        busy = 1'b0;
      end
    end
  end

  // Driver: present a request until accepted, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(posedge clk); #1;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", W'(in_ready), W'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
    Operation = 3'($urandom_range(0, 7));
  endtask

  // Driver: wait for the result, optionally stall, then consume it.
  // hold < 0 means out_ready is already high and the first DONE cycle consumes.
  task automatic wait_result(input int hold, output logic [W-1:0] res, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    res = Result;
    if (!out_valid) begin
      check("result_timeout", W'(out_valid), W'(1'b1));
      out_ready = 1'b0;
      return;
    end
    if (hold < 0) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      SrcA      = $urandom;
      Operation = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("hold_result", Result, res);
      check("hold_valid", W'(out_valid), W'(1'b1));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Directed vectors with hand-computed results
  localparam int ND = 14;
  logic [2:0]   t_op [ND] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
  logic [W-1:0] t_a  [ND] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                              32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'h12345678};
  logic [W-1:0] t_b  [ND] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                              32'd16};
  logic [W-1:0] t_exp[ND] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                              32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'h23456780};

  // Watchdog so the run always ends
  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Reset and test sequence
  initial begin : main
    logic [W-1:0] res;
    int           lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // MUL 7 x -3 with out_ready already high
    out_ready = 1'b1;
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    wait_result(-1, res, lat);
    check("mul_7xm3", res, 32'hFFFFFFEB);
    check("mul_latency", W'(lat), W'(LAT));
    @(negedge clk);
    check("ready_after_hs", W'(in_ready), W'(1'b1));

    // Directed table, also pinning the reference model
    for (int i = 0; i < ND; i++) begin
      check($sformatf("model_dir%0d", i), model(t_op[i], t_a[i], t_b[i]), t_exp[i]);
      issue(t_op[i], t_a[i], t_b[i]);
      wait_result(0, res, lat);
      check($sformatf("dir%0d_result", i), res, t_exp[i]);
      check($sformatf("dir%0d_latency", i), W'(lat), W'(LAT));
    end

    // Backpressure: 5 stalled cycles with in_valid pulses and SrcA churn
    issue(3'd3, 32'hDEADBEEF, 32'h12345679);
    wait_result(5, res, lat);
    check("bp_result", res, model(3'd3, 32'hDEADBEEF, 32'h12345679));
    @(negedge clk);
    check("bp_ready_after_hs", W'(in_ready), W'(1'b1));
    check("bp_result_kept", Result, res);

    // Reset in CALC cycle 10
    issue(3'd1, $urandom, $urandom);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", W'(in_ready), W'(1'b1));
    check("rst_mid_out_valid", W'(out_valid), W'(1'b0));
    check("rst_mid_result", Result, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(3'd5, 32'd9, 32'd3);
    wait_result(0, res, lat);
    check("divu_9_3", res, 32'd3);
    check("divu_9_3_latency", W'(lat), W'(LAT));

    // Randomized operations with random stalls
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rnd_val();
      b  = rnd_val();
      issue(op, a, b);
      wait_result($urandom_range(0, 3), res, lat);
      check("rnd_result", res, model(op, a, b));
      check("rnd_latency", W'(lat), W'(LAT));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
